// File: rtl/bist_march_controller.sv
// -----------------------------------------------------------------------------
// bist_march_controller
//
// March C- sequencer and read-response comparator for an SRAM BIST.
// Walks the six March C- elements over every address, drives the SRAM
// control/address/data lines, compares each read word one cycle later, and
// reports a single pass/fail verdict plus first-failure diagnostics.
//
// Ports
//   Clock      in   rising-edge clock
//   Reset      in   synchronous, active-high reset
//   Start      in   begin a test (sampled in IDLE or DONE only)
//   SramCe     out  chip enable, high on every op cycle
//   SramWe     out  1 = write, 0 = read
//   SramAddr   out  SRAM address
//   SramDin    out  SRAM write data (all-0 / all-1 backgrounds)
//   SramDout   in   SRAM read data, valid the cycle after a read
//   Busy       out  test in progress
//   Done       out  test complete (level)
//   GoNoGo     out  1 = memory passed, valid while Done
//   FailAddr   out  address of the first mismatch
//   FailElem   out  March element (0-5) of the first mismatch
//   FailCount  out  mismatching reads, saturating at 255
// -----------------------------------------------------------------------------
module bist_march_controller #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic              SramCe,
  output logic              SramWe,
  output logic [ADDR_W-1:0] SramAddr,
  output logic [DATA_W-1:0] SramDin,
  input  logic [DATA_W-1:0] SramDout,
  output logic              Busy,
  output logic              Done,
  output logic              GoNoGo,
  output logic [ADDR_W-1:0] FailAddr,
  output logic [2:0]        FailElem,
  output logic [7:0]        FailCount
);

  // Element states are numbered to match their March element index, so the
  // low three bits of the state double as the element number for diagnostics.
  localparam logic [3:0] S_M0    = 4'd0;
  localparam logic [3:0] S_M1    = 4'd1;
  localparam logic [3:0] S_M2    = 4'd2;
  localparam logic [3:0] S_M3    = 4'd3;
  localparam logic [3:0] S_M4    = 4'd4;
  localparam logic [3:0] S_M5    = 4'd5;
  localparam logic [3:0] S_IDLE  = 4'd6;
  localparam logic [3:0] S_DRAIN = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_ONES = '1;

  logic [3:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_phase;      // 0 = read half, 1 = write half of a pair
  logic              r_cmp_valid;
  logic [DATA_W-1:0] r_cmp_exp;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic [2:0]        r_cmp_elem;
  logic [7:0]        r_fail_count;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [2:0]        r_fail_elem;
  logic              r_go;

  logic w_op, w_pair, w_read, w_write, w_down, w_wr_one, w_rd_one;
  logic w_last_addr, w_elem_end, w_next_down, w_mismatch, w_start;
  logic [2:0] w_elem;

  assign w_op        = (r_state <= S_M5);
  assign w_pair      = (r_state >= S_M1) && (r_state <= S_M4);
  assign w_read      = (w_pair && !r_phase) || (r_state == S_M5);
  assign w_write     = (r_state == S_M0) || (w_pair && r_phase);
  assign w_down      = (r_state == S_M3) || (r_state == S_M4);
  assign w_wr_one    = (r_state == S_M1) || (r_state == S_M3);
  assign w_rd_one    = (r_state == S_M2) || (r_state == S_M4);
  assign w_last_addr = w_down ? (r_addr == ADDR_ZERO) : (r_addr == ADDR_LAST);
  // An element ends on its terminal address, after the write half if paired.
  assign w_elem_end  = w_op && w_last_addr && (!w_pair || r_phase);
  // M3 and M4 run downward, so the counter reloads high when entering them.
  assign w_next_down = (r_state == S_M2) || (r_state == S_M3);
  assign w_mismatch  = r_cmp_valid && (SramDout != r_cmp_exp);
  assign w_start     = ((r_state == S_IDLE) || (r_state == S_DONE)) && Start;
  assign w_elem      = r_state[2:0];

  // Sequencer: state, address counter and read/write phase.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_addr  <= ADDR_ZERO;
      r_phase <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_state <= S_M0;
            r_addr  <= ADDR_ZERO;
            r_phase <= 1'b0;
          end
        end
        S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
          if (w_pair && !r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (w_elem_end) begin
              r_state <= (r_state == S_M5) ? S_DRAIN : r_state + 4'd1;
              r_addr  <= w_next_down ? ADDR_LAST : ADDR_ZERO;
            end else begin
              r_addr  <= w_down ? r_addr - ADDR_ONE : r_addr + ADDR_ONE;
            end
          end
        end
        S_DRAIN: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Compare pipeline: capture what a read cycle expects, check it next cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cmp_valid <= 1'b0;
      r_cmp_exp   <= DATA_ZERO;
      r_cmp_addr  <= ADDR_ZERO;
      r_cmp_elem  <= 3'd0;
    end else begin
      r_cmp_valid <= w_read;
      r_cmp_exp   <= w_rd_one ? DATA_ONES : DATA_ZERO;
      r_cmp_addr  <= r_addr;
      r_cmp_elem  <= w_elem;
    end
  end

  // Result registers. The verdict folds in the compare still in flight while
  // in DRAIN, so GoNoGo covers the final M5 read.
  always_ff @(posedge Clock) begin
    if (Reset || w_start) begin
      r_fail_count <= 8'd0;
      r_fail_addr  <= ADDR_ZERO;
      r_fail_elem  <= 3'd0;
      r_go         <= 1'b0;
    end else begin
      if (w_mismatch) begin
        if (r_fail_count != 8'hFF) r_fail_count <= r_fail_count + 8'd1;
        if (r_fail_count == 8'd0) begin
          r_fail_addr <= r_cmp_addr;
          r_fail_elem <= r_cmp_elem;
        end
      end
      if (r_state == S_DRAIN) r_go <= (r_fail_count == 8'd0) && !w_mismatch;
    end
  end

  assign SramCe    = w_op;
  assign SramWe    = w_write;
  assign SramAddr  = w_op ? r_addr : ADDR_ZERO;
  assign SramDin   = (w_write && w_wr_one) ? DATA_ONES : DATA_ZERO;
  assign Busy      = w_op || (r_state == S_DRAIN);
  assign Done      = (r_state == S_DONE);
  assign GoNoGo    = r_go;
  assign FailAddr  = r_fail_addr;
  assign FailElem  = r_fail_elem;
  assign FailCount = r_fail_count;

endmodule

// File: tb/tb_bist_march_controller.sv
// -----------------------------------------------------------------------------
// tb_bist_march_controller
//
// Drives bist_march_controller against a behavioural 256x4 SRAM with optional
// single-bit stuck-at faults or a forced read value. Expected op sequences and
// verdicts come from a March C- reference model built from element tables.
// -----------------------------------------------------------------------------
module tb_bist_march_controller;

  localparam int AW  = 8;
  localparam int DW  = 4;
  localparam int N   = 1 << AW;
  localparam int OPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sram_ce, sram_we, busy, done, go;
  logic [AW-1:0] sram_addr, fail_addr;
  logic [DW-1:0] sram_din, sram_dout;
  logic [2:0]    fail_elem;
  logic [7:0]    fail_count;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bist_march_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock    (clk),
    .Reset    (rst),
    .Start    (start),
    .SramCe   (sram_ce),
    .SramWe   (sram_we),
    .SramAddr (sram_addr),
    .SramDin  (sram_din),
    .SramDout (sram_dout),
    .Busy     (busy),
    .Done     (done),
    .GoNoGo   (go),
    .FailAddr (fail_addr),
    .FailElem (fail_elem),
    .FailCount(fail_count)
  );

  // ---------------- fault configuration and SRAM model ----------------
  int   f_mode = 0;   // 0 = healthy, 1 = stuck-at bit, 2 = read data forced to 0101
  int   f_addr = 0;
  int   f_bit  = 0;
  logic f_val  = 1'b0;

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
    logic [DW-1:0] r;
    r = v;
    if (f_mode == 1 && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  logic [DW-1:0] mem [N];
  logic [DW-1:0] dout_q;

  always @(posedge clk) begin
    if (sram_ce && sram_we) mem[sram_addr] <= sram_din;
    if (sram_ce && !sram_we) dout_q <= faulty(mem[sram_addr], int'(sram_addr));
  end

  assign sram_dout = (f_mode == 2) ? 4'b0101 : dout_q;

  // ---------------- March C- reference model ----------------
  // Per element: direction (1 = down), read background (-1 = none),
  // write background (-1 = none).
  int el_down [6] = '{0, 0, 0, 1, 1, 0};
  int el_rd   [6] = '{-1, 0, 1, 0, 1, 0};
  int el_wr   [6] = '{0, 1, 0, 1, 0, -1};

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;

  op_t exp_ops[$];
  int  exp_cnt, exp_faddr, exp_felem;

  task automatic build_expectation();
    logic [DW-1:0] m [N];
    logic [DW-1:0] got, want;
    op_t o;
    int a;
    exp_ops.delete();
    exp_cnt = 0; exp_faddr = 0; exp_felem = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (el_down[e] != 0) ? (N - 1 - i) : i;
        if (el_rd[e] >= 0) begin
          o.we = 1'b0; o.addr = AW'(a); o.din = '0;
          exp_ops.push_back(o);
          got  = (f_mode == 2) ? 4'b0101 : faulty(m[a], a);
          want = (el_rd[e] != 0) ? '1 : '0;
          if (got !== want) begin
            if (exp_cnt == 0) begin exp_faddr = a; exp_felem = e; end
            if (exp_cnt < 255) exp_cnt++;
          end
        end
        if (el_wr[e] >= 0) begin
          o.we = 1'b1; o.addr = AW'(a); o.din = (el_wr[e] != 0) ? '1 : '0;
          exp_ops.push_back(o);
          m[a] = o.din;
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fault(input int mode, input int a, input int b, input logic v);
    f_mode = mode; f_addr = a; f_bit = b; f_val = v;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called just after the edge that sampled Start; follows the whole run
  // through DRAIN and DONE and checks the op stream and the verdict.
  task automatic observe_run(input string name);
    int  first_bad;
    op_t o;
    first_bad = -1;
    build_expectation();
    for (int k = 0; k < OPS + 2; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check({name, "_busy_at_start"}, {30'd0, busy, done}, 32'h2);
        check({name, "_regs_cleared"}, {19'd0, go, fail_count, fail_elem}, 32'h0);
        check({name, "_addr_cleared"}, 32'(fail_addr), 32'h0);
      end
      if (k < OPS) begin
        o = exp_ops[k];
        if (first_bad < 0 &&
            !(sram_ce === 1'b1 && busy === 1'b1 && done === 1'b0 &&
              sram_we === o.we && sram_addr === o.addr &&
              (!o.we || sram_din === o.din)))
          first_bad = k;
      end else if (k == OPS) begin
        check({name, "_drain"}, {sram_ce, sram_we, busy, done, sram_din, sram_addr}, 32'h2000);
      end else begin
        check({name, "_done"}, {29'd0, sram_ce, busy, done}, 32'h1);
      end
    end
    check({name, "_op_seq_first_bad"}, 32'(first_bad), 32'hFFFF_FFFF);
    check({name, "_gonogo"}, {31'd0, go}, (exp_cnt == 0) ? 32'h1 : 32'h0);
    check({name, "_fail_count"}, 32'(fail_count), 32'(exp_cnt));
    check({name, "_fail_addr"}, 32'(fail_addr), 32'(exp_faddr));
    check({name, "_fail_elem"}, 32'(fail_elem), 32'(exp_felem));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {sram_ce, sram_we, busy, done, go, fail_count, fail_elem, sram_din, sram_addr, fail_addr},
          32'h0);
    rst = 1'b0;

    set_fault(0, 0, 0, 1'b0);
    pulse_start(); observe_run("healthy");

    set_fault(1, 8'h3A, 2, 1'b0);
    pulse_start(); observe_run("sa0_3a_b2");

    set_fault(1, 8'hFF, 0, 1'b1);
    pulse_start(); observe_run("sa1_ff_b0");

    set_fault(2, 0, 0, 1'b0);
    pulse_start(); observe_run("forced_0101");

    for (int r = 0; r < 3; r++) begin
      set_fault(1, int'($urandom_range(0, N - 1)), int'($urandom_range(0, DW - 1)),
                1'($urandom_range(0, 1)));
      pulse_start(); observe_run($sformatf("rand%0d_a%0h_b%0d_v%0d", r, f_addr, f_bit, f_val));
    end

    // Abort mid-test, then a clean run.
    set_fault(0, 0, 0, 1'b0);
    pulse_start();
    repeat (999) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_abort", {28'd0, sram_we, sram_ce, busy, done}, 32'h0);
    rst = 1'b0;
    pulse_start(); observe_run("after_abort");

    // Start held high through a faulty run; it must restart only from DONE.
    set_fault(1, 8'h3A, 2, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    observe_run("held_start");
    @(posedge clk);
    #1 start = 1'b0;
    set_fault(0, 0, 0, 1'b0);
    observe_run("held_rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_march_controller.md
# bist_march_controller

March C- sequencer and response comparator for the 256x4b SRAM BIST. It sits upstream of the memory array and drives every SRAM address, data and write-enable cycle. It compares each read word against the expected background one cycle later and reports a single pass/fail verdict. `Checker_BIST` instantiates it and exposes its `GoNoGo` output directly.

## Interface
Parameters:
- `ADDR_W`, default 8: SRAM address width; the address space is 2^ADDR_W words.
- `DATA_W`, default 4: SRAM word width; backgrounds are all-0 and all-1.

Ports:
- `Clock`, in, 1: single clock; all logic is rising-edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `Start`, in, 1: begin a test; sampled only in IDLE or DONE.
- `SramCe`, out, 1: SRAM chip enable; high on every op cycle.
- `SramWe`, out, 1: SRAM write enable; 1 = write, 0 = read.
- `SramAddr`, out, ADDR_W: SRAM address.
- `SramDin`, out, DATA_W: SRAM write data.
- `SramDout`, in, DATA_W: SRAM read data, valid one cycle after a read cycle.
- `Busy`, out, 1: test in progress.
- `Done`, out, 1: test complete (level).
- `GoNoGo`, out, 1: 1 = memory passed; valid while `Done`=1.
- `FailAddr`, out, ADDR_W: address of the first mismatch.
- `FailElem`, out, 3: March element (0-5) of the first mismatch.
- `FailCount`, out, 8: mismatching reads, saturating at 255.

## Operation
- States: IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE.
- March elements, with N = 2^ADDR_W:
  - M0: up, w0.
  - M1: up, (r0, w1).
  - M2: up, (r1, w0).
  - M3: down, (r0, w1).
  - M4: down, (r1, w0).
  - M5: up, r0.
- Op-cycle counts:
  - M0 and M5 take 1 op cycle per address.
  - M1 to M4 take 2 op cycles per address: a read cycle, then a write cycle to the same address.
  - Total = 10N op cycles = 2560 at default parameters.
- Address direction:
  - Up elements run 0 to N-1.
  - Down elements run N-1 to 0.
  - The address counter reloads at each element boundary; there are no idle cycles between elements.
- Data patterns: "0" = all zeros, "1" = all ones on `SramDin` and on the expected value.
- Transitions:
  - IDLE or DONE with `Start`=1 goes to M0.
  - Each M element advances after the last op at its terminal address.
  - M5 goes to DRAIN, and DRAIN goes to DONE.
  - DONE holds until `Start` or `Reset`.
- Compare pipeline:
  - Each read cycle registers (valid, expected, address, element).
  - On the next cycle, `SramDout` is compared with the expected value.
  - A mismatch increments `FailCount`, saturating at 255.
  - On the first mismatch only, `FailAddr` and `FailElem` are latched.
- `Start` in DONE clears `FailCount`, `FailAddr`, `FailElem` and `GoNoGo`, then restarts at M0.
- `Start` while `Busy`=1 is ignored.
- `GoNoGo` is set to 1 on entry to DONE iff `FailCount`=0; otherwise it is 0.
- SRAM outputs and status outputs are driven from registered state and counters only; there is no combinational path from `Start` or `SramDout` to any output.
- Outside op cycles (IDLE, DRAIN, DONE): `SramCe`=0, `SramWe`=0, `SramAddr`=0, `SramDin`=0.

## Timing
- Reset values: all outputs 0, state IDLE.
- `Reset` mid-test:
  - Aborts at the next edge.
  - `SramWe` and `SramCe` drop the following cycle.
  - The pending compare is discarded.
- The edge E0 that samples `Start` sets `Busy`=1; the first op (M0 w0, address 0) occupies the cycle after E0.
- Op cycles run from E0 to E2560; the last M5 read is at address 255 in the cycle E2559 to E2560.
- E2560 enters DRAIN; the last compare is registered at E2561.
- E2561 enters DONE:
  - `Done` goes to 1 and `Busy` goes to 0.
  - `GoNoGo` reflects all 1280 reads, including the final one.
- Read/write pair in M1 to M4:
  - Read cycle: `SramWe`=0.
  - Write cycle (next): `SramWe`=1, same address.
  - The compare of that read happens during the write cycle.
- Element boundary: the last op of element k and the first op of element k+1 are in consecutive cycles.

## Test plan
- Fault-free SRAM model, one `Start` pulse -> 2560 op cycles; `Done`=1 at E2561; `GoNoGo`=1; `FailCount`=0.
- Bit 2 stuck-at-0 at 0x3A -> first fail in M2 (r1); `FailAddr`=0x3A; `FailElem`=2; `FailCount`=2; `GoNoGo`=0.
- Bit 0 stuck-at-1 at 0xFF -> first fail in M1; `FailAddr`=0xFF; `FailElem`=1; `FailCount`=3 (M1, M3, M5).
- `SramDout` forced to 4'b0101 on every cycle -> 1280 mismatches; `FailCount`=255 (saturated); `FailAddr`=0x00; `FailElem`=1.
- `Reset` at cycle 1000 -> next cycle `SramWe`, `SramCe`, `Busy` and `Done` are all 0; a following `Start` completes a clean pass with `GoNoGo`=1.
- `Start` held high for the whole run -> no restart before DONE; the next `Start` in DONE clears the fail registers and reruns, with `Done`=0 and `Busy`=1 after that edge.
